// File: rtl/inst_encode_loader.sv
// Packs decoded instruction fields into 32-bit ARM-format words and writes them
// sequentially into instruction memory, holding the CPU in reset until loaded.
module inst_encode_loader #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                DEPTH     = 64,
    parameter logic [3:0]        COND      = 4'hE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_op,
    input  logic [5:0]        in_funct,
    input  logic [3:0]        in_rn,
    input  logic [3:0]        in_rd,
    input  logic [11:0]       in_src2,
    input  logic [23:0]       in_imm24,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_rst_n,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [6:0]        word_count
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DONE,
        ST_ERROR
    } state_t;

    localparam logic [6:0] DEPTH_CNT = 7'(DEPTH);

    state_t              state_reg;
    state_t              state_next;
    logic                last_seen_reg;
    logic                mem_we_reg;
    logic [ADDR_W-1:0]   mem_addr_reg;
    logic [ADDR_W-1:0]   next_addr_reg;
    logic [31:0]         mem_wdata_reg;
    logic [6:0]          word_count_reg;

    logic                xfer;
    logic                illegal;
    logic                overflow;
    logic                wr_ok;
    logic                new_session;
    logic [31:0]         enc_word;

    assign in_ready    = (state_reg == ST_LOAD) && !last_seen_reg;
    assign xfer        = in_valid && in_ready;
    assign illegal     = (in_op == 2'b11);
    assign overflow    = (word_count_reg == DEPTH_CNT);
    assign wr_ok       = xfer && !illegal && !overflow;
    // A start pulse arriving mid-load is ignored.
    assign new_session = start && (state_reg != ST_LOAD);

    always_comb begin
        enc_word = '0;
        case (in_op)
            2'b00, 2'b01: enc_word = {COND, in_op, in_funct, in_rn, in_rd, in_src2};
            2'b10:        enc_word = {COND, 2'b10, in_funct[5:4], in_imm24};
            default:      enc_word = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) state_next = ST_LOAD;
            end
            ST_LOAD: begin
                if (xfer && (illegal || overflow)) begin
                    state_next = ST_ERROR;
                end else if (last_seen_reg) begin
                    // Final word is being written this cycle.
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (start) state_next = ST_LOAD;
            end
            ST_ERROR: begin
                if (start) state_next = ST_LOAD;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_seen_reg  <= 1'b0;
            mem_we_reg     <= 1'b0;
            mem_addr_reg   <= BASE_ADDR;
            next_addr_reg  <= BASE_ADDR;
            mem_wdata_reg  <= '0;
            word_count_reg <= '0;
        end else begin
            mem_we_reg <= 1'b0;
            if (new_session) begin
                last_seen_reg  <= 1'b0;
                next_addr_reg  <= BASE_ADDR;
                word_count_reg <= '0;
            end else if (wr_ok) begin
                mem_we_reg     <= 1'b1;
                mem_addr_reg   <= next_addr_reg;
                mem_wdata_reg  <= enc_word;
                next_addr_reg  <= next_addr_reg + ADDR_W'(4);
                word_count_reg <= word_count_reg + 7'd1;
                if (in_last) last_seen_reg <= 1'b1;
            end
        end
    end

    assign mem_we     = mem_we_reg;
    assign mem_addr   = mem_addr_reg;
    assign mem_wdata  = mem_wdata_reg;
    assign word_count = word_count_reg;
    assign busy       = (state_reg == ST_LOAD);
    assign done       = (state_reg == ST_DONE);
    assign error      = (state_reg == ST_ERROR);
    assign cpu_rst_n  = (state_reg == ST_DONE);

endmodule

// File: tb/tb_inst_encode_loader.sv
// Directed bench for inst_encode_loader (DEPTH=4 so overflow is reachable).
module tb_inst_encode_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [5:0]  in_funct;
    logic [3:0]  in_rn;
    logic [3:0]  in_rd;
    logic [11:0] in_src2;
    logic [23:0] in_imm24;
    logic        in_last;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_rst_n;
    logic        busy;
    logic        done;
    logic        error;
    logic [6:0]  word_count;

    int checks = 0;
    int errors = 0;

    inst_encode_loader #(
        .ADDR_W    (32),
        .BASE_ADDR (32'h0000_0000),
        .DEPTH     (4),
        .COND      (4'hE)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_funct   (in_funct),
        .in_rn      (in_rn),
        .in_rd      (in_rd),
        .in_src2    (in_src2),
        .in_imm24   (in_imm24),
        .in_last    (in_last),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_rst_n  (cpu_rst_n),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_word(input logic [1:0] op, input logic [5:0] funct, input logic [3:0] rn,
                            input logic [3:0] rd, input logic [11:0] src2, input logic [23:0] imm,
                            input logic last);
        in_valid = 1'b1;
        in_op    = op;
        in_funct = funct;
        in_rn    = rn;
        in_rd    = rd;
        in_src2  = src2;
        in_imm24 = imm;
        in_last  = last;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_op = 2'd0; in_funct = 6'd0;
        in_rn = 4'd0; in_rd = 4'd0; in_src2 = 12'd0; in_imm24 = 24'd0; in_last = 1'b0;
        step(); step();
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_we got %0b exp 0", mem_we); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr got %h exp 0", mem_addr); end
        checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL rst_wdata got %h exp 0", mem_wdata); end
        checks++; if ({in_ready, cpu_rst_n, busy, done, error} !== 5'b0) begin errors++; $display("FAIL rst_flags got %b exp 00000", {in_ready, cpu_rst_n, busy, done, error}); end
        checks++; if (word_count !== 7'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", word_count); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        // start together with in_valid in IDLE: the word must not be taken
        set_word(2'd0, 6'b101000, 4'd2, 4'd1, 12'h005, 24'd0, 1'b1);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL idle_ready got %0b exp 0", in_ready); end
        pulse_start();
        checks++; if (mem_we !== 1'b0 || word_count !== 7'd0) begin errors++; $display("FAIL idle_ignore we=%0b cnt=%0d exp 0/0", mem_we, word_count); end
        checks++; if (in_ready !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL load_ready got %0b/%0b exp 1/1", in_ready, busy); end
        step();
        in_valid = 1'b0;
        $display("write addr=%h data=%h", mem_addr, mem_wdata);
        checks++; if (mem_we !== 1'b1 || mem_addr !== 32'h0 || mem_wdata !== 32'hE282_1005) begin errors++; $display("FAIL single_wr we=%0b addr=%h data=%h exp 1/0/e2821005", mem_we, mem_addr, mem_wdata); end
        checks++; if (in_ready !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL single_rdy ready=%0b done=%0b exp 0/0", in_ready, done); end
        step();
        checks++; if (mem_we !== 1'b0 || done !== 1'b1 || cpu_rst_n !== 1'b1 || word_count !== 7'd1) begin errors++; $display("FAIL single_done we=%0b done=%0b cpu=%0b cnt=%0d exp 0/1/1/1", mem_we, done, cpu_rst_n, word_count); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_data [3];
        exp_data[0] = 32'hE590_3008;
        exp_data[1] = 32'hE081_2003;
        exp_data[2] = 32'hEAFF_FFFE;
        pulse_start();
        checks++; if (cpu_rst_n !== 1'b0 || busy !== 1'b1 || done !== 1'b0 || word_count !== 7'd0) begin errors++; $display("FAIL b2b_restart cpu=%0b busy=%0b done=%0b cnt=%0d exp 0/1/0/0", cpu_rst_n, busy, done, word_count); end
        for (int i = 0; i < 3; i++) begin
            case (i)
                0: set_word(2'd1, 6'b011001, 4'd0, 4'd3, 12'h008, 24'd0, 1'b0);
                1: set_word(2'd0, 6'b001000, 4'd1, 4'd2, 12'h003, 24'd0, 1'b0);
                default: set_word(2'd2, 6'b100000, 4'd0, 4'd0, 12'h000, 24'hFFFFFE, 1'b1);
            endcase
            step();
            $display("write addr=%h data=%h", mem_addr, mem_wdata);
            checks++; if (mem_we !== 1'b1 || mem_addr !== 32'(4 * i) || mem_wdata !== exp_data[i]) begin errors++; $display("FAIL b2b_wr%0d we=%0b addr=%h data=%h exp 1/%h/%h", i, mem_we, mem_addr, mem_wdata, 32'(4 * i), exp_data[i]); end
        end
        in_valid = 1'b0;
        step();
        checks++; if (done !== 1'b1 || mem_we !== 1'b0 || word_count !== 7'd3) begin errors++; $display("FAIL b2b_done done=%0b we=%0b cnt=%0d exp 1/0/3", done, mem_we, word_count); end
    endtask

    task automatic test_gaps();
        pulse_start();
        set_word(2'd0, 6'b001000, 4'd4, 4'd5, 12'h0AB, 24'd0, 1'b0);
        step();
        in_valid = 1'b0;
        checks++; if (mem_we !== 1'b1 || mem_addr !== 32'h0 || mem_wdata !== 32'hE084_50AB) begin errors++; $display("FAIL gap_wr0 we=%0b addr=%h data=%h exp 1/0/e08450ab", mem_we, mem_addr, mem_wdata); end
        // start during LOAD is ignored
        pulse_start();
        checks++; if (mem_we !== 1'b0 || word_count !== 7'd1 || busy !== 1'b1) begin errors++; $display("FAIL gap_idle we=%0b cnt=%0d busy=%0b exp 0/1/1", mem_we, word_count, busy); end
        step();
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL gap_idle2 we=%0b exp 0", mem_we); end
        set_word(2'd1, 6'b011000, 4'd1, 4'd7, 12'h010, 24'd0, 1'b1);
        step();
        in_valid = 1'b0;
        checks++; if (mem_we !== 1'b1 || mem_addr !== 32'h4 || mem_wdata !== 32'hE581_7010) begin errors++; $display("FAIL gap_wr1 we=%0b addr=%h data=%h exp 1/4/e5817010", mem_we, mem_addr, mem_wdata); end
        step();
        checks++; if (done !== 1'b1 || word_count !== 7'd2) begin errors++; $display("FAIL gap_done done=%0b cnt=%0d exp 1/2", done, word_count); end
    endtask

    task automatic test_illegal();
        pulse_start();
        set_word(2'd0, 6'b101000, 4'd2, 4'd1, 12'h005, 24'd0, 1'b0);
        step();
        checks++; if (mem_we !== 1'b1 || mem_addr !== 32'h0) begin errors++; $display("FAIL ill_wr0 we=%0b addr=%h exp 1/0", mem_we, mem_addr); end
        set_word(2'd3, 6'b111111, 4'd1, 4'd1, 12'h111, 24'd0, 1'b0);
        step();
        in_valid = 1'b0;
        checks++; if (mem_we !== 1'b0 || error !== 1'b1 || cpu_rst_n !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL ill_err we=%0b err=%0b cpu=%0b rdy=%0b exp 0/1/0/0", mem_we, error, cpu_rst_n, in_ready); end
        checks++; if (word_count !== 7'd1) begin errors++; $display("FAIL ill_count got %0d exp 1", word_count); end
        step();
        checks++; if (error !== 1'b1 || mem_we !== 1'b0) begin errors++; $display("FAIL ill_hold err=%0b we=%0b exp 1/0", error, mem_we); end
        pulse_start();
        checks++; if (busy !== 1'b1 || error !== 1'b0 || word_count !== 7'd0) begin errors++; $display("FAIL ill_restart busy=%0b err=%0b cnt=%0d exp 1/0/0", busy, error, word_count); end
    endtask

    task automatic test_overflow();
        // already in LOAD from the previous restart
        for (int i = 0; i < 4; i++) begin
            set_word(2'd0, 6'b000100, 4'(i), 4'(i), 12'(i), 24'd0, 1'b0);
            step();
            checks++; if (mem_we !== 1'b1 || mem_addr !== 32'(4 * i) || word_count !== 7'(i + 1)) begin errors++; $display("FAIL ovf_wr%0d we=%0b addr=%h cnt=%0d exp 1/%h/%0d", i, mem_we, mem_addr, word_count, 32'(4 * i), i + 1); end
        end
        set_word(2'd0, 6'b000100, 4'd9, 4'd9, 12'h009, 24'd0, 1'b0);
        step();
        in_valid = 1'b0;
        checks++; if (mem_we !== 1'b0 || error !== 1'b1 || word_count !== 7'd4) begin errors++; $display("FAIL ovf_err we=%0b err=%0b cnt=%0d exp 0/1/4", mem_we, error, word_count); end
    endtask

    task automatic test_async_reset();
        pulse_start();
        for (int i = 0; i < 2; i++) begin
            set_word(2'd0, 6'b001000, 4'd1, 4'd1, 12'(i), 24'd0, 1'b0);
            step();
        end
        checks++; if (mem_we !== 1'b1 || mem_addr !== 32'h4) begin errors++; $display("FAIL ar_wr1 we=%0b addr=%h exp 1/4", mem_we, mem_addr); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0 || word_count !== 7'd0) begin errors++; $display("FAIL ar_async we=%0b addr=%h data=%h cnt=%0d exp 0/0/0/0", mem_we, mem_addr, mem_wdata, word_count); end
        checks++; if ({in_ready, cpu_rst_n, busy, done, error} !== 5'b0) begin errors++; $display("FAIL ar_flags got %b exp 00000", {in_ready, cpu_rst_n, busy, done, error}); end
        step();
        checks++; if (mem_we !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL ar_held we=%0b busy=%0b exp 0/0", mem_we, busy); end
        in_valid = 1'b0;
        rst_n = 1'b1;
        step();
        pulse_start();
        set_word(2'd0, 6'b101000, 4'd2, 4'd1, 12'h005, 24'd0, 1'b1);
        step();
        in_valid = 1'b0;
        checks++; if (mem_we !== 1'b1 || mem_addr !== 32'h0 || mem_wdata !== 32'hE282_1005) begin errors++; $display("FAIL ar_reload we=%0b addr=%h data=%h exp 1/0/e2821005", mem_we, mem_addr, mem_wdata); end
        step();
        checks++; if (done !== 1'b1 || word_count !== 7'd1) begin errors++; $display("FAIL ar_done done=%0b cnt=%0d exp 1/1", done, word_count); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_gaps();
        test_illegal();
        test_overflow();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
